// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute unit with single-cycle logic/add/sub and a bit-serial shifter.
// Define SEQ_ALU_MUL_EN to compile in the shift-add multiplier (op 4'b1000).
module seq_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0101;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
`endif

  localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_MUL = 2'd2} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
`endif

  state_t           state_r;
  state_t           state_s;
  logic             accept_s;
  logic             is_shift_s;
  logic             load_s;
  logic             left_r;
  logic             done_r;
  logic             zero_r;
  logic [SW-1:0]    shamt_s;
  logic [SW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] quick_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] result_r;
`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] prod_s;
`endif

  assign accept_s   = start && (state_r == ST_IDLE);
  assign shamt_s    = b[SW-1:0];
  assign is_shift_s = (Operation == OP_SLL) || (Operation == OP_SRL);
  assign step_s     = left_r ? {acc_r[WIDTH-2:0], 1'b0} : {1'b0, acc_r[WIDTH-1:1]};
`ifdef SEQ_ALU_MUL_EN
  assign prod_s     = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
`endif

  // Single-cycle result; a shift reaching here always has a zero shift amount.
  always_comb begin
    quick_s = '0;
    case (Operation)
      OP_AND:  quick_s = a & b;
      OP_OR:   quick_s = a | b;
      OP_ADD:  quick_s = a + b;
      OP_SUB:  quick_s = a - b;
      OP_SLL:  quick_s = a;
      OP_SRL:  quick_s = a;
      default: quick_s = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_shift_s && (shamt_s != '0)) begin
          state_s = ST_SHIFT;
`ifdef SEQ_ALU_MUL_EN
        end else if (accept_s && (Operation == OP_MUL)) begin
          state_s = ST_MUL;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      ST_MUL: begin
        if (cnt_r == '0) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MUL;
        end
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode: when to publish a result and which value it is.
  always_comb begin
    load_s = 1'b0;
    res_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (state_s == ST_IDLE)) begin
          load_s = 1'b1;
          res_s  = quick_s;
        end else begin
          load_s = 1'b0;
          res_s  = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          load_s = 1'b1;
          res_s  = step_s;
        end else begin
          load_s = 1'b0;
          res_s  = '0;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      ST_MUL: begin
        if (cnt_r == '0) begin
          load_s = 1'b1;
          res_s  = prod_s;
        end else begin
          load_s = 1'b0;
          res_s  = '0;
        end
      end
`endif
      default: begin
        load_s = 1'b0;
        res_s  = '0;
      end
    endcase
  end

  // Datapath: operand capture, iteration registers and result/flag outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_r   <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b1;
      acc_r    <= '0;
      cnt_r    <= '0;
      left_r   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_r  <= '0;
      mplier_r <= '0;
`endif
    end else begin
      done_r <= load_s;
      if (load_s) begin
        result_r <= res_s;
        zero_r   <= (res_s == '0);
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            acc_r  <= a;
            cnt_r  <= shamt_s;
            left_r <= (Operation == OP_SLL);
`ifdef SEQ_ALU_MUL_EN
            // Counter runs WIDTH-1 down to 0, one iteration per value.
            if (Operation == OP_MUL) begin
              acc_r    <= '0;
              cnt_r    <= '1;
              mcand_r  <= a;
              mplier_r <= b;
            end
`endif
          end
        end
        ST_SHIFT: begin
          acc_r <= step_s;
          cnt_r <= cnt_r - CNT_ONE;
        end
`ifdef SEQ_ALU_MUL_EN
        ST_MUL: begin
          acc_r    <= prod_s;
          mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r - CNT_ONE;
        end
`endif
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy   = (state_r != ST_IDLE);
  assign done   = done_r;
  assign Result = result_r;
  assign Zero   = zero_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu; expectations are queued at issue and popped on done.
module tb_seq_alu;

  localparam int W   = 64;
  localparam int LIM = 200;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   Operation;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic         Zero;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    int           lat;
    int           busy_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Operation(Operation),
    .a(a), .b(b), .busy(busy), .done(done), .Result(Result), .Zero(Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the limit expires).
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] res, input int lat,
                       input int bcyc);
    exp_t e;
    int cycles;
    int busy_cnt;
    e.res = res; e.zero = (res == 64'd0); e.lat = lat; e.busy_cyc = bcyc;
    sb.push_back(e);
    start = 1'b1; Operation = op; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 64'h5a5a_5a5a_5a5a_5a5a; b = 64'h0000_0000_0000_0021;
    cycles = 1; busy_cnt = 0;
    while (done !== 1'b1 && cycles < LIM) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 64'(cycles), 64'(e.lat));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(e.busy_cyc));
    check({tag, "_res"}, Result, e.res);
    check({tag, "_zero"}, {63'd0, Zero}, {63'd0, e.zero});
  endtask

  initial begin
    int dcnt;
    n_vec = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; Operation = 4'b0000; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_res", Result, 64'd0);
    check("rst_zero", {63'd0, Zero}, 64'd1);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of SLL 1 << 40.
    start = 1'b1; Operation = 4'b0011; a = 64'd1; b = 64'd40;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_res", Result, 64'd0);
    check("abort_zero", {63'd0, Zero}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);

    // Wrap-around add, then back-to-back SUB in the done cycle.
    do_op("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0);
    do_op("sub_b2b", 4'b0110, 64'd10, 64'd3, 64'd7, 1, 0);
    do_op("and", 4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1, 0);
    do_op("or", 4'b0001, 64'h0F, 64'hF0, 64'hFF, 1, 0);
    do_op("op_0111", 4'b0111, 64'h1234, 64'h5678, 64'd0, 1, 0);
    do_op("sll_63", 4'b0011, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 64, 63);
    do_op("sll_5", 4'b0011, 64'h0123_4567_89AB_CDEF, 64'd5, 64'h2468_ACF1_3579_BDE0, 6, 5);
    do_op("srl_0", 4'b0101, 64'h80, 64'd0, 64'h80, 1, 0);
    @(negedge clk);
    check("done_one_pulse", {63'd0, done}, 64'd0);

    // Start pulsed while SRL 0x100 >> 4 is running must be ignored.
    start = 1'b1; Operation = 4'b0101; a = 64'h100; b = 64'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; Operation = 4'b0010; a = 64'd5; b = 64'd5;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        dcnt++;
        check("ign_res", Result, 64'h10);
      end
      @(negedge clk);
    end
    check("ign_done_count", 64'(dcnt), 64'd1);
    check("ign_final_res", Result, 64'h10);

`ifdef SEQ_ALU_MUL_EN
    do_op("mul_small", 4'b1000, 64'd12345, 64'd6789, 64'd83810205, 65, 64);
    do_op("mul_wrap", 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 64);
`else
    do_op("mul_off", 4'b1000, 64'd3, 64'd4, 64'd0, 1, 0);
`endif
    do_op("sub_neg", 4'b0110, 64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle 64-bit execute unit that sits directly downstream of the ALU control decoder. It consumes the decoder's 4-bit `Operation` code together with two register operands, performs the operation, and returns a registered `Result` and `Zero` flag through a start/busy/done handshake. Logic ops, add and subtract complete in one cycle. Shifts use a one-bit-per-cycle shifter to save area, and an optional shift-add multiplier can be compiled in.

## Interface
- `WIDTH`, 64, operand and result width (power of two, ≥8)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only while `busy`=0
- `Operation`  in  4  op code from ALU control, sampled with `start`
- `a`  in  WIDTH  operand A, sampled with `start`
- `b`  in  WIDTH  operand B, sampled with `start`; `b[$clog2(WIDTH)-1:0]` is the shift amount
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse when `Result`/`Zero` update
- `Result`  out  WIDTH  registered result, held until next `done`
- `Zero`  out  1  registered, equals (`Result`==0)

## Operation
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0011 SLL
  - 0101 SRL
  - 1000 MUL (only with macro)
  - any other code: `Result`=0
- Arithmetic is modulo 2^WIDTH; carry, overflow and MUL high half are discarded.
- States and transitions:
  - IDLE → SHIFT on `start` with SLL/SRL and shamt>0.
  - IDLE → MUL on `start` with MUL.
  - IDLE → IDLE for all other ops.
  - SHIFT → IDLE when the counter reaches 0.
  - MUL → IDLE after WIDTH iterations.
- IDLE behaviour:
  - On `start` with a one-cycle op, `Result`/`Zero` load at that edge and `done`=1 on the next cycle.
  - Shift with shamt=0 is treated as a one-cycle op (`Result`=`a`).
- SHIFT:
  - Accumulator loads `a` and counter loads shamt.
  - Each cycle the accumulator shifts by one bit (SLL left, SRL logical right, zero-fill) and the counter decrements.
  - On the edge where the counter reaches 0, the accumulator is written to `Result` and `done` pulses.
- MUL:
  - Multiplicand is `a`, multiplier is `b`; product register is cleared.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand; then shift the multiplicand left 1 and the multiplier right 1.
  - After WIDTH cycles the low WIDTH bits go to `Result`.
- `busy` = (state != IDLE).
- `start` while `busy`=1 is ignored; no queueing.
- `Operation`, `a` and `b` are captured at start; later changes have no effect on the running operation.
- Back-to-back: `start` may be asserted in the same cycle `done`=1, and is accepted.
- Reset (any time, including mid-operation):
  - State returns to IDLE; counter and accumulators are cleared.
  - `busy`=0, `done`=0, `Result`=0, `Zero`=1.
  - An aborted operation produces no `done`.

## Timing
- Latency counts from the edge sampling `start` to the cycle `done`=1:
  - AND, OR, ADD, SUB, unknown op, shift by 0: 1 cycle
  - SLL/SRL by N>0: N+1 cycles; `busy`=1 for N cycles
  - MUL: WIDTH+1 cycles; `busy`=1 for WIDTH cycles
- `done` is high for exactly one cycle per accepted `start`.
- `Result` and `Zero` change only on the edge that raises `done`, or on reset.
- Throughput for one-cycle ops is one per clock.

## Configuration
- `SEQ_ALU_MUL_EN` defined:
  - MUL state, multiplier datapath and op 1000 are compiled in.
- Macro undefined:
  - No multiplier logic; op 1000 is treated as unknown (`Result`=0, `Zero`=1, latency 1).
  - State register has no MUL encoding.

## Test plan
- Reset asserted mid-SLL (`a`=1, shamt=40, reset at cycle 10):
  - Outputs immediately `busy`=0, `done`=0, `Result`=0, `Zero`=1.
  - No `done` after release.
- ADD `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=1:
  - `done` next cycle, `Result`=0, `Zero`=1.
  - Then SUB 10−3 issued in the `done` cycle gives `Result`=7 one cycle later.
- AND 0xF0F0 & 0xFF00 → 0xF000.
- OR 0x0F & 0xF0 → 0xFF.
- Op 0111 → `Result`=0, `Zero`=1.
- Each of these takes 1 cycle.
- SLL `a`=1, `b`=63 → `busy` for 63 cycles, `done` at cycle 64, `Result`=0x8000_0000_0000_0000.
- SRL `a`=0x80, `b`=0 → 1 cycle, `Result`=0x80.
- `start` pulsed during `busy` with ADD 5+5:
  - Ignored; running SRL 0x100>>4 finishes with `Result`=0x10 and only one `done`.
- With `SEQ_ALU_MUL_EN`:
  - MUL 12345×6789 → `Result`=83810205 at cycle 65.
  - MUL 0xFFFF_FFFF_FFFF_FFFF×2 → 0xFFFF_FFFF_FFFF_FFFE.
- Without the macro, MUL 3×4 → `Result`=0 in 1 cycle.
